// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU with a start/ready/done handshake.
// Add, sub, and, or, xor, slt and sltu finish in one cycle. Shifts (sll, srl, sra)
// move one bit per cycle, so a shift by n takes n+1 cycles from accept to done.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      operation request; taken only while ready=1
//   ALUControl op code (000 add, 001 sub, 010 and, 011 or, 100 sll,
//              101 slt/sltu, 110 srl/sra, 111 xor)
//   funct7b5   with 110: 1 = sra, 0 = srl
//   funct3b0   with 101: 1 = sltu, 0 = slt
//   SrcA, SrcB operands; SrcB[SHW-1:0] is the shift amount
//   flush      synchronous abort; wins over start
//   ready      idle and able to accept start
//   done       one-cycle pulse when ALUResult/Zero are updated
//   ALUResult  registered result, held until the next completion
//   Zero       registered (ALUResult == 0)
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic             funct7b5,
  input  logic             funct3b0,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] shreg;
  logic             shift_left;
  logic             shift_fill;   // bit shifted in from the top on right shifts

  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             is_shift;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] shift_next;

  assign shamt    = SrcB[SHW-1:0];
  assign accept   = start && ready && (state == IDLE) && !flush;
  assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL);

  // One-bit step of the iterative shifter.
  assign shift_next = shift_left ? {shreg[WIDTH-2:0], 1'b0}
                                 : {shift_fill, shreg[WIDTH-1:1]};

  // Single-cycle result. Shift codes only reach this path with shamt=0,
  // where the result is SrcA unchanged.
  always_comb begin
    // NOTE: default assignment first so no path leaves op_result unassigned (no latch).
    op_result = '0;
    case (ALUControl)
      OP_ADD: op_result = SrcA + SrcB;
      OP_SUB: op_result = SrcA - SrcB;
      OP_AND: op_result = SrcA & SrcB;
      OP_OR:  op_result = SrcA | SrcB;
      OP_SLL: op_result = SrcA;
      OP_SLT: op_result = funct3b0
                          ? {{(WIDTH-1){1'b0}}, (SrcA < SrcB)}
                          : {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SRL: op_result = SrcA;
      OP_XOR: op_result = SrcA ^ SrcB;
      default: op_result = '0;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      ALUResult  <= '0;
      Zero       <= 1'b1;
      cnt        <= '0;
      shreg      <= '0;
      shift_left <= 1'b0;
      shift_fill <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              shreg      <= SrcA;
              cnt        <= shamt;
              shift_left <= (ALUControl == OP_SLL);
              // srl fills with 0; sra replicates the sampled sign bit.
              shift_fill <= (ALUControl == OP_SRL) && funct7b5 && SrcA[WIDTH-1];
              state      <= SHIFT;
              ready      <= 1'b0;
            end else begin
              ALUResult <= op_result;
              Zero      <= (op_result == '0);
              done      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (flush) begin
            state <= IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt   <= cnt - SHW'(1);
            shreg <= shift_next;
            // Last step: load the final value directly so the partial
            // shift never shows on ALUResult.
            if (cnt == SHW'(1)) begin
              ALUResult <= shift_next;
              Zero      <= (shift_next == '0);
              done      <= 1'b1;
              state     <= IDLE;
              ready     <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  ALUControl;
  logic        funct7b5;
  logic        funct3b0;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        ready;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
    .funct7b5(funct7b5), .funct3b0(funct3b0), .SrcA(SrcA), .SrcB(SrcB),
    .flush(flush), .ready(ready), .done(done), .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  // Reference model: result straight from the op definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] ctl, input logic f7,
                                             input logic f3, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned       sh;
    logic signed [31:0] sa;
    logic signed [31:0] sr;
    sh = int'(b[4:0]);
    sa = a;
    sr = sa >>> sh;
    case (ctl)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a << sh;
      3'd5: if (f3) return (a < b) ? 32'd1 : 32'd0;
            else    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return f7 ? sr : (a >> sh);
      default: return a ^ b;
    endcase
  endfunction

  // Cycles from accept to done: n+1 for a shift by n>0, otherwise 1.
  function automatic int ref_latency(input logic [2:0] ctl, input logic [31:0] b);
    if ((ctl == 3'd4 || ctl == 3'd6) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op while idle and wait (bounded) for done. Inputs are scrambled
  // right after the accept edge. lat=0 means done never came.
  task automatic exec(input logic [2:0] ctl, input logic f7, input logic f3,
                      input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int ready_low,
                      output logic [31:0] res, output logic z);
    lat = 0; ready_low = 0; res = 'x; z = 1'bx;
    @(negedge clk);
    ALUControl = ctl; funct7b5 = f7; funct3b0 = f3; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom);
        funct7b5 = 1'($urandom); funct3b0 = 1'($urandom);
      end
      if (done) begin
        lat = i; res = ALUResult; z = Zero;
        break;
      end
      if (!ready) ready_low++;
    end
  endtask

  task automatic test_reset();
    int lat, rl; logic [31:0] r; logic z;
    exec(3'd0, 1'b0, 1'b0, 32'h1234, 32'h1, lat, rl, r, z);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (ALUResult !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", ALUResult); end
    n_cmp++; if (Zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", Zero); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    int lat, rl; logic [31:0] r; logic z;
    exec(3'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, lat, rl, r, z);
    n_cmp++; if (r !== 32'h80000000) begin n_err++; $display("FAIL add_result: got %h expected 80000000", r); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL add_zero: got %b expected 0", z); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d expected 1", lat); end
    exec(3'd1, 1'b0, 1'b0, 32'd5, 32'd5, lat, rl, r, z);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL sub_result: got %h expected 0", r); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL sub_zero: got %b expected 1", z); end
  endtask

  task automatic test_compare();
    int lat, rl; logic [31:0] r; logic z;
    exec(3'd5, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, lat, rl, r, z);
    n_cmp++; if (r !== 32'd1) begin n_err++; $display("FAIL slt_result: got %h expected 1", r); end
    exec(3'd5, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1, lat, rl, r, z);
    n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL sltu_result: got %h expected 0", r); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL sltu_zero: got %b expected 1", z); end
  endtask

  task automatic test_shift_latency();
    int lat, rl; logic [31:0] r; logic z;
    exec(3'd6, 1'b1, 1'b0, 32'h80000000, 32'd4, lat, rl, r, z);
    n_cmp++; if (r !== 32'hF8000000) begin n_err++; $display("FAIL sra_result: got %h expected F8000000", r); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL sra_latency: got %0d expected 5", lat); end
    n_cmp++; if (rl !== 4) begin n_err++; $display("FAIL sra_ready_low: got %0d expected 4", rl); end
    exec(3'd6, 1'b0, 1'b0, 32'h80000000, 32'd4, lat, rl, r, z);
    n_cmp++; if (r !== 32'h08000000) begin n_err++; $display("FAIL srl_result: got %h expected 08000000", r); end
    exec(3'd4, 1'b0, 1'b0, 32'h1, 32'd31, lat, rl, r, z);
    n_cmp++; if (r !== 32'h80000000) begin n_err++; $display("FAIL sll31_result: got %h expected 80000000", r); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL sll31_latency: got %0d expected 32", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    bit          seen;
    a = $urandom | 32'h1;
    // sll by 0 then add 2+3 on the very next edge.
    @(negedge clk);
    ALUControl = 3'd4; SrcA = a; SrcB = 32'h00000020; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || ALUResult !== a) begin n_err++; $display("FAIL b2b_sll0: got done=%b %h expected done=1 %h", done, ALUResult, a); end
    ALUControl = 3'd0; SrcA = 32'd2; SrcB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b1 || ALUResult !== 32'd5) begin n_err++; $display("FAIL b2b_add: got done=%b %h expected done=1 5", done, ALUResult); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_pulse: got %b expected 0", done); end
    // Accept in the same cycle as a shift's done.
    ALUControl = 3'd6; funct7b5 = 1'b0; SrcA = 32'hF0; SrcB = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1 || ALUResult !== 32'h1E) begin n_err++; $display("FAIL b2b_srl: got done=%b %h expected done=1 1e", seen, ALUResult); end
    ALUControl = 3'd0; SrcA = 32'd7; SrcB = 32'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b1 || ALUResult !== 32'd15) begin n_err++; $display("FAIL b2b_after_shift: got done=%b %h expected done=1 f", done, ALUResult); end
  endtask

  task automatic test_flush();
    int lat, rl; logic [31:0] r; logic z;
    bit seen;
    exec(3'd0, 1'b0, 1'b0, 32'd5, 32'd0, lat, rl, r, z);
    @(negedge clk);
    ALUControl = 3'd4; SrcA = $urandom | 32'h1; SrcB = 32'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL flush_shift_started: got ready=%b expected 0", ready); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b expected 0", seen); end
    n_cmp++; if (ALUResult !== 32'd5 || Zero !== 1'b0) begin n_err++; $display("FAIL flush_hold: got %h z=%b expected 5 z=0", ALUResult, Zero); end
    // flush in IDLE blocks a same-edge start.
    ALUControl = 3'd0; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++; if (done !== 1'b0 || ALUResult !== 32'd5) begin n_err++; $display("FAIL flush_idle: got done=%b %h expected done=0 5", done, ALUResult); end
  endtask

  task automatic test_reset_abort();
    int lat, rl; logic [31:0] r; logic z;
    bit seen;
    exec(3'd0, 1'b0, 1'b0, 32'd5, 32'd0, lat, rl, r, z);
    @(negedge clk);
    ALUControl = 3'd4; SrcA = $urandom | 32'h1; SrcB = 32'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (ALUResult !== 32'h0 || Zero !== 1'b1) begin n_err++; $display("FAIL rst_abort_result: got %h z=%b expected 0 z=1", ALUResult, Zero); end
    n_cmp++; if (ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL rst_abort_hs: got ready=%b done=%b expected 1 0", ready, done); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0 || ALUResult !== 32'h0) begin n_err++; $display("FAIL rst_abort_quiet: got done=%b %h expected 0 0", seen, ALUResult); end
  endtask

  task automatic test_random();
    int lat, rl, elat;
    logic [31:0] r, a, b, exp;
    logic [2:0]  ctl;
    logic        f7, f3, z;
    for (int k = 0; k < 40; k++) begin
      ctl = 3'($urandom); f7 = 1'($urandom); f3 = 1'($urandom);
      a = $urandom; b = $urandom;
      if (k % 5 == 0) b = a;   // exercise equal operands
      exp  = ref_result(ctl, f7, f3, a, b);
      elat = ref_latency(ctl, b);
      exec(ctl, f7, f3, a, b, lat, rl, r, z);
      n_cmp++; if (r !== exp || z !== (exp == 32'h0)) begin n_err++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h z=%b expected %h", ctl, a, b, r, z, exp); end
      n_cmp++; if (lat !== elat || rl !== elat - 1) begin n_err++; $display("FAIL rand_timing op=%0d b=%h: got lat=%0d ready_low=%0d expected lat=%0d", ctl, b, lat, rl, elat); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; ALUControl = 3'd0;
    funct7b5 = 1'b0; funct3b0 = 1'b0; SrcA = '0; SrcB = '0;
    #2;
    n_cmp++; if (ready !== 1'b1 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      n_err++; $display("FAIL init_reset: got ready=%b done=%b %h z=%b expected 1 0 0 1", ready, done, ALUResult, Zero);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_add_sub();
    test_compare();
    test_shift_latency();
    test_back_to_back();
    test_flush();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Execute-stage ALU sitting directly downstream of the ALU decoder. It consumes the 3-bit ALUControl code plus two operands and produces ALUResult and Zero. Add, sub, logic and compare ops complete in one cycle. Shifts run iteratively at one bit per cycle to save area. A start/ready/done handshake lets the core's control logic stall fetch while a shift is in progress.

Parameters:
WIDTH, 32, operand and result width in bits.
SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to begin an operation; accepted only when ready=1.
ALUControl  input  3  op code: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt/sltu, 110 srl/sra, 111 xor.
funct7b5  input  1  with ALUControl=110: 1 selects sra, 0 selects srl; ignored otherwise.
funct3b0  input  1  with ALUControl=101: 1 selects sltu, 0 selects slt; ignored otherwise.
SrcA  input  WIDTH  operand A.
SrcB  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount.
flush  input  1  synchronous abort of any in-flight operation.
ready  output  1  high when idle and able to accept start.
done  output  1  one-cycle pulse when ALUResult/Zero become valid.
ALUResult  output  WIDTH  registered result; holds until the next completion.
Zero  output  1  registered, equals (ALUResult==0); updated together with ALUResult.

Behaviour:
- Reset (async, reset=1): state=IDLE, ready=1, done=0, ALUResult=0, Zero=1, shift counter=0, internal shift register=0.
- States: IDLE, SHIFT.
- Accept: a start is accepted at the clock edge where start=1 and ready=1. Operands, ALUControl, funct7b5 and funct3b0 are sampled only at that edge. Input changes afterwards have no effect on the operation in flight.
- Single-cycle ops (000, 001, 010, 011, 101, 111, and shifts with shamt=0):
  - State stays IDLE.
  - At the accept edge, ALUResult and Zero are loaded; done=1 for exactly the following cycle.
  - ready stays 1, so back-to-back starts give done every cycle.
- Arithmetic rules:
  - add/sub are modulo 2^WIDTH; carry and overflow are discarded.
  - slt is a signed compare; sltu is unsigned. The result is zero-extended 0 or 1.
  - sub with SrcA==SrcB gives Zero=1 (used by beq/bne).
- Shift ops with shamt=n>0:
  - At accept: shift register <= SrcA, counter <= n, state goes to SHIFT, ready drops to 0 in the next cycle.
  - Each SHIFT cycle shifts by one bit and decrements the counter:
    - sll fills with 0.
    - srl fills with 0.
    - sra fills with the sampled SrcA[WIDTH-1].
  - On the edge where the counter goes 1->0: ALUResult/Zero are loaded from the final value, state returns to IDLE, and done=1 in the next cycle.
  - Latency: accept at edge T gives done high in the cycle after edge T+n. Total latency is n+1 cycles (n ranges 1..WIDTH-1).
  - The last shift step and the result load happen on the same edge; the partial shift value never appears on ALUResult.
- start while ready=0 is ignored (not queued).
- The first accept after returning to IDLE is legal in the same cycle as done.
- flush:
  - In SHIFT: next edge returns to IDLE, clears the counter, no done, ALUResult/Zero keep their previous values.
  - In IDLE: suppresses any start on the same edge.
  - flush has priority over start.
- reset asserted mid-shift: immediately returns all outputs to reset values; no done is produced.
- ALUControl unknown or X is not expected from the decoder. The result for those codes is don't-care, but state must still return to IDLE.

Test Plan:
- Reset: assert reset mid-cycle without a clock edge -> ready=1, done=0, ALUResult=0, Zero=1 immediately.
- Add/sub:
  - add SrcA=0x7FFFFFFF, SrcB=1 -> ALUResult=0x80000000, Zero=0, done one cycle after accept.
  - sub 5-5 -> ALUResult=0, Zero=1.
- Compare: slt SrcA=0xFFFFFFFF, SrcB=1 -> ALUResult=1; sltu with the same operands -> ALUResult=0.
- Shift latency:
  - sra SrcA=0x80000000, SrcB=4 -> ready low for 4 cycles, done at accept+5, ALUResult=0xF8000000.
  - srl with the same operands -> 0x08000000.
  - sll 1 by 31 -> 0x80000000 at accept+32.
- Shift zero and back-to-back: sll shamt=0 followed immediately by add 2+3 -> done on two consecutive cycles, results SrcA then 5.
- Abort:
  - flush at cycle 2 of an sll by 10 (previous ALUResult=0x5) -> no done, ALUResult stays 0x5, ready=1 next cycle.
  - Repeat the scenario with reset instead of flush -> ALUResult=0, Zero=1.
